// File: rtl/video_capture.sv
// video_capture: pairs two IN_W beats into one RGB pixel, derives raw raster counters from
// active-low syncs, windows the active area and reports frame length and input lock.
// Optional build macro CAPTURE_TESTPATTERN_EN swaps captured colour for 8 vertical bars.
module video_capture #(
  parameter int unsigned IN_W         = 12,
  parameter int unsigned CH_W         = 8,
  parameter int unsigned CNT_W        = 12,
  parameter int unsigned LOCK_TIMEOUT = 2048
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [IN_W-1:0]  indata,
  input  logic             _hsync,
  input  logic             _vsync,
  input  logic [CNT_W-1:0] hstart,
  input  logic [CNT_W-1:0] vstart,
  input  logic [CNT_W-1:0] width,
  input  logic [CNT_W-1:0] height,
  output logic [CH_W-1:0]  red,
  output logic [CH_W-1:0]  green,
  output logic [CH_W-1:0]  blue,
  output logic             de,
  output logic             pix_valid,
  output logic [CNT_W-1:0] counterX,
  output logic [CNT_W-1:0] counterY,
  output logic             frame_start,
  output logic [CNT_W-1:0] frame_lines,
  output logic             odd_frame,
  output logic             locked
);

  localparam int unsigned      LW       = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [LW-1:0]    LOCK_MAX = LW'(LOCK_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic             hs_q, vs_q, hs_fall, vs_fall, frame_edge;
  logic [CNT_W-1:0] raw_x_q, raw_y_q;
  logic [CNT_W-1:0] hstart_q, vstart_q, width_q, height_q;
  logic [CNT_W-1:0] frame_lines_q;
  logic             frame_start_q;
  logic [CNT_W:0]   hend, vend;
  logic [CNT_W-1:0] rel_x, rel_y, pix_x;
  logic             active, phase;
  logic [IN_W-1:0]  buf_q;
  logic             buf_valid_q;
  logic [CH_W-1:0]  red_q, green_q, blue_q, src_r, src_g, src_b;
  logic             de_q, pv_q;
  logic [CNT_W-1:0] cx_q, cy_q;
  logic [LW-1:0]    lock_cnt_q;
  logic [2:0]       edges_q;
  logic             locked_q;

  // Sync registers idle high so releasing reset never fakes a falling edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hs_q <= 1'b1;
      vs_q <= 1'b1;
    end else begin
      hs_q <= _hsync;
      vs_q <= _vsync;
    end
  end

  assign hs_fall    = hs_q & ~_hsync;
  assign vs_fall    = vs_q & ~_vsync;
  assign frame_edge = hs_fall & vs_fall;  // a lone vsync edge is ignored

  // Raw raster counters, frame length capture and per-frame geometry sampling.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      raw_x_q       <= '0;
      raw_y_q       <= '0;
      hstart_q      <= '0;
      vstart_q      <= '0;
      width_q       <= '0;
      height_q      <= '0;
      frame_lines_q <= '0;
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= frame_edge;
      if (hs_fall) begin
        raw_x_q <= '0;
        if (vs_fall) begin
          raw_y_q       <= '0;
          frame_lines_q <= raw_y_q + CNT_W'(1);
          hstart_q      <= hstart;
          vstart_q      <= vstart;
          width_q       <= width;
          height_q      <= height;
        end else if (raw_y_q != CNT_MAX) begin
          raw_y_q <= raw_y_q + CNT_W'(1);
        end
      end else if (raw_x_q != CNT_MAX) begin
        raw_x_q <= raw_x_q + CNT_W'(1);
      end
    end
  end

  // Active window test; bounds are one bit wider so large geometry cannot wrap.
  always_comb begin
    hend   = {1'b0, hstart_q} + {width_q, 1'b0};
    vend   = {1'b0, vstart_q} + {1'b0, height_q};
    rel_x  = raw_x_q - hstart_q;
    rel_y  = raw_y_q - vstart_q;
    pix_x  = {1'b0, rel_x[CNT_W-1:1]};
    phase  = rel_x[0];
    active = (raw_x_q >= hstart_q) && ({1'b0, raw_x_q} < hend) &&
             (raw_y_q >= vstart_q) && ({1'b0, raw_y_q} < vend);
  end

`ifdef CAPTURE_TESTPATTERN_EN
  logic [2:0]       bar_idx_q, idx_eff;
  logic [CNT_W-1:0] bar_pos_q, pos_eff, bar_w;

  // Bar colour: bit2 kills green, bit1 kills red, bit0 kills blue (white..black order).
  always_comb begin
    bar_w   = {3'b000, width_q[CNT_W-1:3]};
    idx_eff = (pix_x == '0) ? 3'd0 : bar_idx_q;
    pos_eff = (pix_x == '0) ? '0 : bar_pos_q;
    src_r   = {CH_W{~idx_eff[1]}};
    src_g   = {CH_W{~idx_eff[2]}};
    src_b   = {CH_W{~idx_eff[0]}};
  end

  // Walk across bars once per emitted pixel; the last bar absorbs any remainder.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bar_idx_q <= '0;
      bar_pos_q <= '0;
    end else if (active && phase && buf_valid_q) begin
      if ((pos_eff + CNT_W'(1) >= bar_w) && (idx_eff != 3'd7)) begin
        bar_idx_q <= idx_eff + 3'd1;
        bar_pos_q <= '0;
      end else begin
        bar_idx_q <= idx_eff;
        bar_pos_q <= pos_eff + CNT_W'(1);
      end
    end
  end
`else
  logic [2*IN_W-1:0] pix_word;

  // Captured colour: first beat is the high half of the packed pixel.
  always_comb begin
    pix_word = {buf_q, indata};
    src_r    = pix_word[2*IN_W-1 -: CH_W];
    src_g    = pix_word[2*IN_W-1-CH_W -: CH_W];
    src_b    = pix_word[CH_W-1:0];
  end
`endif

  // Beat pairing and output register; buf_valid_q guards against half pixels after reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      buf_q       <= '0;
      buf_valid_q <= 1'b0;
      red_q       <= '0;
      green_q     <= '0;
      blue_q      <= '0;
      de_q        <= 1'b0;
      pv_q        <= 1'b0;
      cx_q        <= '0;
      cy_q        <= '0;
    end else if (!active) begin
      red_q       <= '0;
      green_q     <= '0;
      blue_q      <= '0;
      de_q        <= 1'b0;
      pv_q        <= 1'b0;
      buf_valid_q <= 1'b0;
    end else if (!phase) begin
      buf_q       <= indata;
      buf_valid_q <= 1'b1;
      de_q        <= 1'b0;
      pv_q        <= 1'b0;
    end else begin
      buf_valid_q <= 1'b0;
      de_q        <= buf_valid_q;
      pv_q        <= buf_valid_q;
      if (buf_valid_q) begin
        red_q   <= src_r;
        green_q <= src_g;
        blue_q  <= src_b;
        cx_q    <= pix_x;
        cy_q    <= rel_y;
      end
    end
  end

  // Lock detect: 4 timely hsync edges set lock, LOCK_TIMEOUT quiet clocks drop it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lock_cnt_q <= '0;
      edges_q    <= '0;
      locked_q   <= 1'b0;
    end else if (hs_fall) begin
      lock_cnt_q <= '0;
      if (lock_cnt_q != LOCK_MAX) begin
        if (edges_q != 3'd4) edges_q <= edges_q + 3'd1;
        if (edges_q >= 3'd3) locked_q <= 1'b1;
      end else begin
        edges_q <= 3'd1;
      end
    end else if (lock_cnt_q != LOCK_MAX) begin
      lock_cnt_q <= lock_cnt_q + LW'(1);
      if (lock_cnt_q == LOCK_MAX - LW'(1)) begin
        locked_q <= 1'b0;
        edges_q  <= '0;
      end
    end
  end

  assign red         = red_q;
  assign green       = green_q;
  assign blue        = blue_q;
  assign de          = de_q;
  assign pix_valid   = pv_q;
  assign counterX    = cx_q;
  assign counterY    = cy_q;
  assign frame_start = frame_start_q;
  assign frame_lines = frame_lines_q;
  assign odd_frame   = frame_lines_q[0];
  assign locked      = locked_q;

endmodule

// File: tb/tb_video_capture.sv
// tb_video_capture: drives line/frame timing with random beats and checks against a
// raster model that tracks line numbers, beat positions and expected pixels arithmetically.
module tb_video_capture;

  localparam int LOCK_T = 2048;

  logic        clock = 1'b0;
  logic        reset;
  logic [11:0] indata;
  logic        hsync_n, vsync_n;
  logic [11:0] hstart, vstart, width, height;
  logic [7:0]  red, green, blue;
  logic        de, pix_valid, frame_start, odd_frame, locked;
  logic [11:0] counterX, counterY, frame_lines;

  video_capture dut (
    .clock      (clock),
    .reset      (reset),
    .indata     (indata),
    ._hsync     (hsync_n),
    ._vsync     (vsync_n),
    .hstart     (hstart),
    .vstart     (vstart),
    .width      (width),
    .height     (height),
    .red        (red),
    .green      (green),
    .blue       (blue),
    .de         (de),
    .pix_valid  (pix_valid),
    .counterX   (counterX),
    .counterY   (counterY),
    .frame_start(frame_start),
    .frame_lines(frame_lines),
    .odd_frame  (odd_frame),
    .locked     (locked)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state
  int g_hs, g_vs, g_w, g_h;
  bit geom_ok;
  int line_y;
  int lines_since;
  int frame_pix, frame_fs;
  bit pat_mode;
  bit first_seen;
  int first_r, first_g, first_b, first_cx, first_cy;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One line of `len` clocks (only the first `stop` driven); hsync low on the first clock.
  task automatic run_line(input int len, input bit vs_edge, input int stop);
    int held, x, pix, er, eg, eb, ecx, ecy, exp_fl;
    bit in_win, exp_pv, exp_fs;
    held = 0; exp_fl = 0;
    if (vs_edge) begin
      exp_fl = lines_since + 1;
      lines_since = 0;
      line_y = 0;
      g_hs = int'(hstart); g_vs = int'(vstart); g_w = int'(width); g_h = int'(height);
      geom_ok = 1'b1;
    end else begin
      lines_since++;
      line_y++;
    end
    for (int i = 0; i < stop && i < len; i++) begin
      x = i - 1;
      hsync_n = (i != 0);
      vsync_n = !(i == 0 && vs_edge);
      indata  = 12'($urandom);
      in_win  = geom_ok && (i >= 1) && (x >= g_hs) && (x < g_hs + 2 * g_w) &&
                (line_y >= g_vs) && (line_y < g_vs + g_h);
      if (pat_mode && in_win && x == g_hs)     indata = 12'hABC;
      if (pat_mode && in_win && x == g_hs + 1) indata = 12'hDEF;
      exp_pv = in_win && (((x - g_hs) % 2) == 1);
      er = 0; eg = 0; eb = 0; ecx = 0; ecy = 0;
      if (in_win && !exp_pv) held = int'(indata);
      if (exp_pv) begin
        pix = held * 4096 + int'(indata);
        er  = (pix >> 16) & 255;
        eg  = (pix >> 8) & 255;
        eb  = pix & 255;
        ecx = (x - g_hs) / 2;
        ecy = line_y - g_vs;
      end
      exp_fs = (i == 0) && vs_edge;
      tick();
      if (exp_pv || pix_valid) begin
        n_cmp++;
        if (pix_valid !== exp_pv || de !== exp_pv || red !== 8'(er) || green !== 8'(eg) ||
            blue !== 8'(eb) || counterX !== 12'(ecx) || counterY !== 12'(ecy)) begin
          n_bad++;
          $display("FAIL pixel y=%0d x=%0d: got pv=%b de=%b rgb=%h/%h/%h xy=%0d,%0d required pv=%b rgb=%h/%h/%h xy=%0d,%0d",
                   line_y, x, pix_valid, de, red, green, blue, counterX, counterY,
                   exp_pv, er[7:0], eg[7:0], eb[7:0], ecx, ecy);
        end
      end else if (!in_win) begin
        n_cmp++;
        if (de !== 1'b0 || red !== 8'h0 || green !== 8'h0 || blue !== 8'h0) begin
          n_bad++;
          $display("FAIL inactive y=%0d x=%0d: got de=%b rgb=%h/%h/%h required de=0 rgb=0",
                   line_y, x, de, red, green, blue);
        end
      end
      if (exp_fs || frame_start) begin
        n_cmp++;
        if (frame_start !== exp_fs) begin
          n_bad++;
          $display("FAIL frame_start y=%0d i=%0d: got %b required %b", line_y, i, frame_start, exp_fs);
        end
      end
      if (exp_fs) begin
        n_cmp++;
        if (frame_lines !== 12'(exp_fl) || odd_frame !== exp_fl[0]) begin
          n_bad++;
          $display("FAIL frame_lines: got %0d odd=%b required %0d odd=%b",
                   frame_lines, odd_frame, exp_fl, exp_fl[0]);
        end
      end
      if (pix_valid) begin
        frame_pix++;
        if (!first_seen) begin
          first_seen = 1'b1;
          first_r = int'(red); first_g = int'(green); first_b = int'(blue);
          first_cx = int'(counterX); first_cy = int'(counterY);
        end
      end
      if (frame_start) frame_fs++;
    end
  endtask

  task automatic run_frame(input int nlines, input int len);
    frame_pix = 0; frame_fs = 0; first_seen = 1'b0;
    run_line(len, 1'b1, len);
    for (int k = 1; k < nlines; k++) run_line(len, 1'b0, len);
    n_cmp++;
    if (frame_pix != g_w * g_h) begin
      n_bad++;
      $display("FAIL pixel_count: got %0d required %0d", frame_pix, g_w * g_h);
    end
    n_cmp++;
    if (frame_fs != 1) begin
      n_bad++;
      $display("FAIL frame_start_count: got %0d required 1", frame_fs);
    end
  endtask

  task automatic set_geom(input int hs, input int w, input int vs, input int h);
    hstart = 12'(hs); width = 12'(w); vstart = 12'(vs); height = 12'(h);
  endtask

  task automatic do_reset();
    reset = 1'b0; hsync_n = 1'b1; vsync_n = 1'b1;
    tick(); tick();
    reset = 1'b1;
    lines_since = 0; geom_ok = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; hsync_n = 1'b1; vsync_n = 1'b1; indata = 12'h0;
    set_geom(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({red, green, blue, de, pix_valid, counterX, counterY, frame_start, frame_lines,
           odd_frame, locked} !== '0) begin
        n_bad++;
        $display("FAIL reset_outputs: got rgb=%h/%h/%h de=%b pv=%b xy=%h,%h fs=%b fl=%h odd=%b lk=%b required all 0",
                 red, green, blue, de, pix_valid, counterX, counterY, frame_start,
                 frame_lines, odd_frame, locked);
      end
    end
    reset = 1'b1;
    lines_since = 0; geom_ok = 1'b0;
    tick();
    n_cmp++;
    if (locked !== 1'b0 || pix_valid !== 1'b0 || frame_start !== 1'b0) begin
      n_bad++;
      $display("FAIL after_release: got lk=%b pv=%b fs=%b required 0/0/0", locked, pix_valid, frame_start);
    end
  endtask

  task automatic test_pairing();
    set_geom(4, 2, 0, 1);
    pat_mode = 1'b1;
    run_frame(3, 40);
    pat_mode = 1'b0;
    n_cmp++;
    if (first_r != 'hAB || first_g != 'hCD || first_b != 'hEF || first_cx != 0 || first_cy != 0) begin
      n_bad++;
      $display("FAIL pairing: got rgb=%h/%h/%h x=%0d y=%0d required ab/cd/ef x=0 y=0",
               first_r, first_g, first_b, first_cx, first_cy);
    end
  endtask

  task automatic test_frame_length();
    set_geom(2, 3, 1, 2);
    run_frame(263, 16);
    run_frame(262, 16);
    n_cmp++;
    if (frame_lines !== 12'd263 || odd_frame !== 1'b1) begin
      n_bad++;
      $display("FAIL len263: got %0d odd=%b required 263 odd=1", frame_lines, odd_frame);
    end
    run_frame(4, 16);
    n_cmp++;
    if (frame_lines !== 12'd262 || odd_frame !== 1'b0) begin
      n_bad++;
      $display("FAIL len262: got %0d odd=%b required 262 odd=0", frame_lines, odd_frame);
    end
    n_cmp++;
    if (locked !== 1'b1) begin
      n_bad++;
      $display("FAIL lock_steady: got %b required 1", locked);
    end
  endtask

  task automatic test_zero_geometry();
    set_geom(3, 0, 0, 2);
    run_frame(4, 16);
    set_geom(3, 4, 1, 0);
    run_frame(4, 16);
  endtask

  task automatic test_random();
    int hs, w, vs, h;
    for (int f = 0; f < 4; f++) begin
      hs = int'($urandom_range(0, 8));
      w  = int'($urandom_range(1, 12));
      vs = int'($urandom_range(0, 3));
      h  = int'($urandom_range(1, 4));
      set_geom(hs, w, vs, h);
      run_frame(vs + h + int'($urandom_range(1, 3)), 40);
    end
  endtask

  task automatic test_lock();
    do_reset();
    for (int k = 0; k < 3; k++) run_line(858, 1'b0, 858);
    n_cmp++;
    if (locked !== 1'b0) begin
      n_bad++;
      $display("FAIL lock_3_edges: got %b required 0", locked);
    end
    run_line(1, 1'b0, 1);
    n_cmp++;
    if (locked !== 1'b1) begin
      n_bad++;
      $display("FAIL lock_4_edges: got %b required 1", locked);
    end
    hsync_n = 1'b1; vsync_n = 1'b1;
    for (int k = 0; k < LOCK_T - 1; k++) tick();
    n_cmp++;
    if (locked !== 1'b1) begin
      n_bad++;
      $display("FAIL lock_before_timeout: got %b required 1", locked);
    end
    tick();
    n_cmp++;
    if (locked !== 1'b0) begin
      n_bad++;
      $display("FAIL lock_at_timeout: got %b required 0", locked);
    end
    // Line count survives loss of lock: vsync edge reports lines since reset plus one.
    set_geom(2, 2, 0, 1);
    run_frame(3, 16);
  endtask

  task automatic test_reset_mid();
    set_geom(4, 4, 1, 2);
    frame_pix = 0; first_seen = 1'b0;
    run_line(40, 1'b1, 40);
    run_line(40, 1'b0, 7);  // last driven beat is the phase-1 beat at hstart+1
    reset = 1'b0; hsync_n = 1'b1; vsync_n = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({red, green, blue, de, pix_valid, counterX, counterY, frame_start, frame_lines,
           odd_frame, locked} !== '0) begin
        n_bad++;
        $display("FAIL midreset_outputs %0d: got rgb=%h/%h/%h de=%b pv=%b xy=%h,%h fl=%h lk=%b required all 0",
                 i, red, green, blue, de, pix_valid, counterX, counterY, frame_lines, locked);
      end
      if (i < 3) tick();
    end
    reset = 1'b1;
    lines_since = 0; geom_ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      indata = 12'($urandom);
      tick();
      n_cmp++;
      if (pix_valid !== 1'b0 || de !== 1'b0) begin
        n_bad++;
        $display("FAIL partial_pixel %0d: got pv=%b de=%b required 0/0", i, pix_valid, de);
      end
    end
    run_frame(4, 40);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    pat_mode = 1'b0; geom_ok = 1'b0; lines_since = 0; line_y = 0;
    g_hs = 0; g_vs = 0; g_w = 0; g_h = 0;
    test_reset();
    test_pairing();
    test_frame_length();
    test_zero_geometry();
    test_random();
    test_lock();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/video_capture.md
VIDEO_CAPTURE -- requirements
Module: video_capture

Interface
REQ-001 Parameters (name, default, meaning):
- IN_W, 12, input data bus width per beat.
- CH_W, 8, output colour channel width; 3*CH_W SHALL equal 2*IN_W (two beats per pixel).
- CNT_W, 12, width of all counters and geometry inputs.
- LOCK_TIMEOUT, 2048, clocks without an hsync falling edge before lock is lost.
REQ-002 Ports (name, direction, width, meaning):
- clock, in, 1, pixel-beat clock.
- reset, in, 1, asynchronous active-low reset.
- indata, in, IN_W, packed RGB beat.
- _hsync, in, 1, active-low horizontal sync.
- _vsync, in, 1, active-low vertical sync.
- hstart, in, CNT_W, first active raw X count.
- vstart, in, CNT_W, first active raw line.
- width, in, CNT_W, active pixels per line.
- height, in, CNT_W, active lines per frame.
- red, out, CH_W, red channel.
- green, out, CH_W, green channel.
- blue, out, CH_W, blue channel.
- de, out, 1, data enable for the current rgb output.
- pix_valid, out, 1, one-clock strobe per completed pixel.
- counterX, out, CNT_W, active pixel X of the current rgb output.
- counterY, out, CNT_W, active line Y of the current rgb output.
- frame_start, out, 1, one-clock pulse on a frame boundary.
- frame_lines, out, CNT_W, line count of the last complete frame.
- odd_frame, out, 1, frame_lines[0] (odd-length frame, e.g. 263-line 240p).
- locked, out, 1, input timing stable.

Function
REQ-003 Sync edge detection SHALL register _hsync and _vsync; a falling edge is registered=1 and current=0.
REQ-004 raw_x SHALL load 0 on an hsync falling edge; otherwise it increments and saturates at all-ones.
REQ-005 On an hsync falling edge, raw_y SHALL increment, saturating at all-ones.
REQ-006 When a vsync falling edge coincides with an hsync falling edge:
- raw_y SHALL load 0;
- frame_lines SHALL load raw_y+1;
- frame_start SHALL pulse for one clock.
REQ-007 A vsync falling edge with no coincident hsync falling edge SHALL be ignored.
REQ-008 active SHALL be true when hstart <= raw_x < hstart+2*width AND vstart <= raw_y < vstart+height, with sums computed at CNT_W+1 bits (no wrap).
REQ-009 Beat phase SHALL equal bit 0 of (raw_x - hstart).
- Phase 0: buffer indata.
- Phase 1: form {buffer, indata}; red is the top CH_W bits, then green, then blue.
REQ-010 rgb, de=1 and pix_valid=1 SHALL appear one clock after the phase-1 beat is sampled, with counterX/counterY equal to that pixel's coordinates.
REQ-011 counterX SHALL equal (raw_x-hstart)>>1 and counterY SHALL equal raw_y-vstart.
REQ-012 When not active: red=green=blue=0, de=0, pix_valid=0; counterX/counterY hold.
REQ-013 width=0 or height=0 SHALL produce no active pixels.
REQ-014 Geometry inputs SHALL be sampled only on frame_start and are stable for the whole frame.
REQ-015 A lock counter SHALL count clocks since the last hsync falling edge.
- locked SHALL be set after 4 consecutive hsync falling edges, each arriving before LOCK_TIMEOUT.
- locked SHALL clear when the counter reaches LOCK_TIMEOUT.
REQ-016 Loss of lock SHALL NOT reset the counters.

Reset
REQ-017 While reset=0, all outputs SHALL be 0 and all internal state SHALL be cleared.
- Both sync registers SHALL be 1, so no false edge occurs at reset release.
REQ-018 Reset asserted mid-line SHALL abort any partial pixel; the first output after release SHALL be a complete pixel.

Configuration
REQ-019 With CAPTURE_TESTPATTERN_EN defined, active pixels SHALL output 8 vertical colour bars of width/8 each: white, yellow, cyan, green, magenta, red, blue, black.
- Timing and all strobes SHALL be unchanged; indata SHALL be ignored.
REQ-020 Without CAPTURE_TESTPATTERN_EN, rgb SHALL come from indata and no pattern logic SHALL be present.

Verification
REQ-021 Beat pairing: hstart=4, width=2, beats 0xABC and 0xDEF at raw_x 4 and 5 -> red=0xAB, green=0xCD, blue=0xEF, pix_valid=1 one clock later, counterX=0.
REQ-022 Frame length: 263 hsyncs between vsyncs -> frame_lines=263, odd_frame=1, one frame_start pulse; 262 hsyncs -> odd_frame=0.
REQ-023 Boundary: raw_x = hstart+2*width -> de=0 and rgb=0 on the following clock; height=0 -> de never asserts.
REQ-024 Lock: 4 hsyncs spaced 858 clocks -> locked=1; hsync removed -> locked=0 exactly LOCK_TIMEOUT clocks after the last edge.
REQ-025 Reset: reset=0 for 3 clocks mid-active, released on a phase-1 beat -> no pix_valid until the next full beat pair; all outputs 0 during reset.
